// File: rtl/obstacle_spawner_if.sv
// Obstacle type encoding shared with the obstacle slots, and the bundle of
// per-slot signals that runs between the spawner and the slot pool.
package obstacle_pkg;
    typedef enum logic [2:0] {
        NONE         = 3'd0,
        CACTUS_SMALL = 3'd1,
        CACTUS_LARGE = 3'd2,
        PTERODACTYL  = 3'd3
    } type_t;
endpackage

// Request/consume protocol: the spawner holds start[i] high and typ[i] stable
// from the cycle after it arms slot i until the next `update` cycle. Slot i
// latches typ[i] on that `update`, and start[i] drops at the same clock edge.
// At most one start bit is ever set. remove[i] is a level that the slot holds
// high until it re-initialises; only its rising edge frees the slot.
interface obstacle_spawner_if #(
    parameter int N_SLOTS = 3
);
    logic [N_SLOTS-1:0]    start;
    logic [N_SLOTS*3-1:0]  typ;
    logic [N_SLOTS-1:0]    busy;
    logic [N_SLOTS-1:0]    remove;
    logic [N_SLOTS*11-1:0] x_pos;
    logic [N_SLOTS*10-1:0] width;
    logic [N_SLOTS*11-1:0] gap;

    modport master (output start, typ, busy, input remove, x_pos, width, gap);
    modport slave  (input start, typ, busy, output remove, x_pos, width, gap);
endinterface

// File: rtl/obstacle_spawner.sv
// Spawn controller for a pool of obstacle slots: decides once per frame
// whether a new obstacle is due, picks its type, and arms the target slot.
module obstacle_spawner #(
    parameter int N_SLOTS         = 3,
    parameter int MAX_DUP         = 2,
    parameter int MAX_REROLL      = 8,
    parameter int GAME_WIDTH      = 640,
    parameter int PTERO_MIN_SPEED = 8704
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 update,
    input  logic                 run_en,
    input  logic                 crash,
    input  logic [14:0]          speed,
    input  logic [10:0]          rng_data,
    obstacle_spawner_if.master   slots,
    output logic [2:0]           state_dbg
);
    import obstacle_pkg::*;

    localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int RW = $clog2(MAX_REROLL + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_PICK    = 3'd2;
    localparam logic [2:0] S_ARMED   = 3'd3;
    localparam logic [2:0] S_CRASHED = 3'd4;

    logic [2:0]         state;
    logic [N_SLOTS-1:0] start_r;
    logic [N_SLOTS-1:0] busy_r;
    logic [N_SLOTS-1:0] remove_q;
    logic [2:0]         typ_r [N_SLOTS];
    logic [2:0]         hist [MAX_DUP];
    logic [RW-1:0]      reroll_cnt;
    logic [SW-1:0]      last_idx;
    logic [SW-1:0]      tgt_idx;

    logic [N_SLOTS-1:0] tgt_onehot;
    logic [N_SLOTS-1:0] rise;
    logic [N_SLOTS-1:0] clr;
    logic [N_SLOTS-1:0] busy_eff;
    logic               free_any;
    logic [SW-1:0]      free_idx;
    logic signed [12:0] last_end;
    logic               due;
    logic [2:0]         cand;
    logic               dup;
    logic               all_small;
    logic               reject;
    logic [2:0]         fallback;
    logic               last_try;
    logic               unused_ok;

    assign unused_ok = ^rng_data[10:2];

    // Slot clear mask: rising remove edges, except on the armed slot or after a crash.
    always_comb begin
        tgt_onehot = {{(N_SLOTS-1){1'b0}}, 1'b1} << tgt_idx;
        rise       = slots.remove & ~remove_q;
        clr        = rise;
        if (state == S_ARMED) clr = rise & ~tgt_onehot;
        if (state == S_CRASHED) clr = '0;
        busy_eff   = busy_r & ~clr;
    end

    // Lowest-index free slot, seen with this cycle's clears applied.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!busy_eff[i]) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    // Spawn-due test: trailing edge of the last obstacle plus its gap has entered the field.
    always_comb begin
        last_end = signed'({{2{slots.x_pos[int'(last_idx)*11 + 10]}},
                            slots.x_pos[int'(last_idx)*11 +: 11]})
                 + signed'({3'b000, slots.width[int'(last_idx)*10 +: 10]})
                 + signed'({2'b00, slots.gap[int'(last_idx)*11 +: 11]});
        due = (busy_eff == '0) ||
              (busy_eff[last_idx] && free_any && (last_end < signed'(13'(GAME_WIDTH))));
    end

    // Candidate screening against speed gate and repetition history.
    always_comb begin
        cand      = {1'b0, rng_data[1:0]};
        dup       = 1'b1;
        all_small = 1'b1;
        for (int i = 0; i < MAX_DUP; i++) begin
            dup       = dup & (hist[i] == cand);
            all_small = all_small & (hist[i] == CACTUS_SMALL);
        end
        reject   = (cand == NONE) ||
                   ((cand == PTERODACTYL) && (speed < 15'(PTERO_MIN_SPEED))) ||
                   dup;
        fallback = all_small ? CACTUS_LARGE : CACTUS_SMALL;
        last_try = (reroll_cnt == RW'(MAX_REROLL - 1));
    end

    // Main controller: slot bookkeeping and the spawn state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            start_r    <= '0;
            busy_r     <= '0;
            remove_q   <= slots.remove;
            reroll_cnt <= '0;
            last_idx   <= '0;
            tgt_idx    <= '0;
            for (int i = 0; i < N_SLOTS; i++) typ_r[i] <= NONE;
            for (int i = 0; i < MAX_DUP; i++) hist[i] <= NONE;
        end else begin
            remove_q <= slots.remove;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (clr[i]) begin
                    busy_r[i] <= 1'b0;
                    typ_r[i]  <= NONE;
                end
            end
            if (crash) begin
                state   <= S_CRASHED;
                start_r <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (update && run_en) state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (due) begin
                            tgt_idx    <= free_idx;
                            reroll_cnt <= '0;
                            state      <= S_PICK;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PICK: begin
                        if (!run_en) begin
                            state <= S_IDLE;
                        end else if (!reject) begin
                            typ_r[tgt_idx] <= cand;
                            start_r        <= tgt_onehot;
                            state          <= S_ARMED;
                        end else if (last_try) begin
                            typ_r[tgt_idx] <= fallback;
                            start_r        <= tgt_onehot;
                            state          <= S_ARMED;
                        end else begin
                            reroll_cnt <= reroll_cnt + 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (!run_en) begin
                            start_r        <= '0;
                            typ_r[tgt_idx] <= NONE;
                            state          <= S_IDLE;
                        end else if (update) begin
                            start_r         <= '0;
                            busy_r[tgt_idx] <= 1'b1;
                            last_idx        <= tgt_idx;
                            hist[0]         <= typ_r[tgt_idx];
                            for (int i = 1; i < MAX_DUP; i++) hist[i] <= hist[i-1];
                            reroll_cnt      <= '0;
                            state           <= S_IDLE;
                        end
                    end
                    S_CRASHED: state <= S_CRASHED;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end

    // Flatten per-slot registers onto the slot bundle.
    always_comb begin
        slots.start = start_r;
        slots.busy  = busy_r;
        slots.typ   = '0;
        for (int i = 0; i < N_SLOTS; i++) slots.typ[i*3 +: 3] = typ_r[i];
        state_dbg   = state;
    end
endmodule
